// File: rtl/riscv_uart_tx.sv
// UART transmitter: byte FIFO feeding a serializer with a runtime frame format
// (5-8 data bits, none/even/odd parity, 1/2 stop bits) and a baud divisor.
module riscv_uart_tx #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 i_riscv_uarttx_clk,
   input  logic                 i_riscv_uarttx_rst,
   input  logic [7:0]           i_riscv_uarttx_wr_data,
   input  logic                 i_riscv_uarttx_wr_valid,
   input  logic                 i_riscv_uarttx_flush,
   input  logic                 i_riscv_uarttx_enable,
   input  logic [DIV_WIDTH-1:0] i_riscv_uarttx_divisor,
   input  logic [1:0]           i_riscv_uarttx_data_bits,
   input  logic [1:0]           i_riscv_uarttx_parity,
   input  logic                 i_riscv_uarttx_stop2,
   output logic                 o_riscv_uarttx_fifo_full,
   output logic                 o_riscv_uarttx_fifo_empty,
   output logic [CNT_W-1:0]     o_riscv_uarttx_fifo_count,
   output logic                 o_riscv_uarttx_overflow,
   output logic                 o_riscv_uarttx_busy,
   output logic                 o_riscv_uarttx_tx
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_full, r_empty, r_overflow;

   logic [2:0]           r_state;
   logic [DIV_WIDTH-1:0] r_baud_cnt, r_div_m1;
   logic [7:0]           r_shift;
   logic [2:0]           r_bit_idx, r_nbits_m1;
   logic                 r_par_en, r_par_bit, r_stop2, r_stop_idx;
   logic                 r_tx, r_busy;

   logic                 w_push, w_pop, w_can_start, w_bit_end, w_last_stop;
   logic [CNT_W-1:0]     w_count_nxt;
   logic [7:0]           w_head, w_mask;
   logic [DIV_WIDTH-1:0] w_div_m1;
   logic                 w_par_new;

   assign w_push      = i_riscv_uarttx_wr_valid && !r_full && !i_riscv_uarttx_flush;
   assign w_can_start = i_riscv_uarttx_enable && !r_empty && !i_riscv_uarttx_flush;
   assign w_bit_end   = (r_baud_cnt == '0);
   assign w_last_stop = (r_state == S_STOP) && w_bit_end && (!r_stop2 || r_stop_idx);
   assign w_pop       = w_can_start && ((r_state == S_IDLE) || w_last_stop);

   assign w_head   = r_mem[r_rd_ptr];
   assign w_div_m1 = (i_riscv_uarttx_divisor == '0) ? '0
                                                   : i_riscv_uarttx_divisor - DIV_WIDTH'(1);

   always_comb begin
      w_mask = 8'hFF;
      case (i_riscv_uarttx_data_bits)
         2'b00:   w_mask = 8'h1F;
         2'b01:   w_mask = 8'h3F;
         2'b10:   w_mask = 8'h7F;
         default: w_mask = 8'hFF;
      endcase
   end

   // Odd parity is the inverse of the even (XOR) bit over the active data bits.
   assign w_par_new = (^(w_head & w_mask)) ^ (i_riscv_uarttx_parity == 2'b10);

   always_comb begin
      w_count_nxt = r_count;
      if (i_riscv_uarttx_flush)
         w_count_nxt = '0;
      else
         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge i_riscv_uarttx_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_riscv_uarttx_wr_data;
   end

   always_ff @(posedge i_riscv_uarttx_clk or negedge i_riscv_uarttx_rst) begin
      if (!i_riscv_uarttx_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= i_riscv_uarttx_wr_valid && r_full && !i_riscv_uarttx_flush;
         if (i_riscv_uarttx_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge i_riscv_uarttx_clk or negedge i_riscv_uarttx_rst) begin
      if (!i_riscv_uarttx_rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_div_m1   <= '0;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_nbits_m1 <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_stop2    <= 1'b0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else if (w_pop) begin
         // Frame start: capture the byte and the whole frame format together.
         r_state    <= S_START;
         r_tx       <= 1'b0;
         r_busy     <= 1'b1;
         r_baud_cnt <= w_div_m1;
         r_div_m1   <= w_div_m1;
         r_shift    <= w_head;
         r_bit_idx  <= '0;
         r_nbits_m1 <= {1'b1, i_riscv_uarttx_data_bits};
         r_par_en   <= i_riscv_uarttx_parity[0] ^ i_riscv_uarttx_parity[1];
         r_par_bit  <= w_par_new;
         r_stop2    <= i_riscv_uarttx_stop2;
         r_stop_idx <= 1'b0;
      end else if (r_state != S_IDLE) begin
         if (!w_bit_end) begin
            r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
         end else begin
            r_baud_cnt <= r_div_m1;
            case (r_state)
               S_START: begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
               end
               S_DATA: begin
                  if (r_bit_idx == r_nbits_m1) begin
                     r_state    <= r_par_en ? S_PARITY : S_STOP;
                     r_tx       <= r_par_en ? r_par_bit : 1'b1;
                     r_stop_idx <= 1'b0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end
               S_PARITY: begin
                  r_state    <= S_STOP;
                  r_tx       <= 1'b1;
                  r_stop_idx <= 1'b0;
               end
               S_STOP: begin
                  if (r_stop2 && !r_stop_idx) begin
                     r_stop_idx <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_riscv_uarttx_fifo_full  = r_full;
   assign o_riscv_uarttx_fifo_empty = r_empty;
   assign o_riscv_uarttx_fifo_count = r_count;
   assign o_riscv_uarttx_overflow   = r_overflow;
   assign o_riscv_uarttx_busy       = r_busy;
   assign o_riscv_uarttx_tx         = r_tx;

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Self-checking bench for riscv_uart_tx: table vectors, random frames against a
// bit-list line model, and directed FIFO / reset corner sequences.
module tb_riscv_uart_tx;

   localparam int DEPTH = 16;
   localparam int DW    = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          flush = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] divisor = 16'd4;
   logic [1:0]    data_bits = 2'b11;
   logic [1:0]    parity = 2'b00;
   logic          stop2 = 1'b0;
   logic          fifo_full, fifo_empty, overflow, busy, tx;
   logic [CW-1:0] fifo_count;

   always #5 clk = ~clk;

   riscv_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
      .i_riscv_uarttx_clk       (clk),
      .i_riscv_uarttx_rst       (rst_n),
      .i_riscv_uarttx_wr_data   (wr_data),
      .i_riscv_uarttx_wr_valid  (wr_valid),
      .i_riscv_uarttx_flush     (flush),
      .i_riscv_uarttx_enable    (enable),
      .i_riscv_uarttx_divisor   (divisor),
      .i_riscv_uarttx_data_bits (data_bits),
      .i_riscv_uarttx_parity    (parity),
      .i_riscv_uarttx_stop2     (stop2),
      .o_riscv_uarttx_fifo_full (fifo_full),
      .o_riscv_uarttx_fifo_empty(fifo_empty),
      .o_riscv_uarttx_fifo_count(fifo_count),
      .o_riscv_uarttx_overflow  (overflow),
      .o_riscv_uarttx_busy      (busy),
      .o_riscv_uarttx_tx        (tx)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] nbc;
      logic [1:0] par;
      logic       st2;
      int         div;
      int         exp_len;
   } vec_t;

   vec_t          vecs[5];
   int            checks = 0;
   int            errors = 0;
   bit            q_exp[$];
   logic [DW-1:0] pend_div = '0;
   logic [1:0]    pend_par = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line model: list of bit values of one frame, each held for max(div,1) cycles.
   task automatic add_frame(input logic [7:0] b, input logic [1:0] nbc, input logic [1:0] par,
                            input logic st2, input int div);
      bit bits[$];
      int n = 5 + int'(nbc);
      int p = (div == 0) ? 1 : div;
      int ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(b[i]);
         ones += int'(b[i]);
      end
      if (par == 2'b01) bits.push_back(bit'(ones % 2));
      if (par == 2'b10) bits.push_back(bit'(1 - ones % 2));
      bits.push_back(1'b1);
      if (st2) bits.push_back(1'b1);
      foreach (bits[j]) repeat (p) q_exp.push_back(bits[j]);
   endtask

   task automatic push(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Called on the negedge where q_exp[0] must be on the line.
   task automatic compare_stream(input string name, input int chg_at, input int exp_busy);
      int n = q_exp.size();
      int first_bad = -1;
      int busy_cnt = 0;
      logic got = 1'b0;
      bit want = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (tx !== q_exp[i] && first_bad < 0) begin
            first_bad = i;
            got = tx;
            want = q_exp[i];
         end
         if (busy === 1'b1) busy_cnt++;
         if (i == chg_at) begin
            divisor = pend_div;
            parity  = pend_par;
         end
         @(negedge clk);
      end
      checks++;
      if (first_bad >= 0) begin
         errors++;
         $display("FAIL %s line: cycle %0d of %0d tx=%0b expected %0b", name, first_bad, n, got, want);
      end
      check({name, " busy cycles"}, busy_cnt, (exp_busy < 0) ? n : exp_busy);
      check({name, " tx idle after"}, tx, 1);
      check({name, " busy low after"}, busy, 0);
      q_exp.delete();
   endtask

   task automatic run_frame(input string name, input logic [7:0] b, input logic [1:0] nbc,
                            input logic [1:0] par, input logic st2, input int div, input int exp_len);
      data_bits = nbc;
      parity    = par;
      stop2     = st2;
      divisor   = DW'(div);
      add_frame(b, nbc, par, st2, div);
      push(b);
      check({name, " empty drops"}, fifo_empty, 0);
      check({name, " tx high before start"}, tx, 1);
      @(negedge clk);
      check({name, " busy at start"}, busy, 1);
      compare_stream(name, -1, exp_len);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h55, 2'b11, 2'b00, 1'b0, 4, 40};
      vecs[1] = '{8'h41, 2'b10, 2'b01, 1'b1, 3, 33};
      vecs[2] = '{8'hA5, 2'b00, 2'b10, 1'b0, 2, 16};
      vecs[3] = '{8'h3C, 2'b01, 2'b11, 1'b1, 0, 9};
      vecs[4] = '{8'hFF, 2'b11, 2'b10, 1'b1, 5, 60};

      repeat (3) @(negedge clk);
      check("reset tx", tx, 1);
      check("reset busy", busy, 0);
      check("reset full", fifo_full, 0);
      check("reset empty", fifo_empty, 1);
      check("reset count", fifo_count, 0);
      check("reset overflow", overflow, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);

      foreach (vecs[v])
         run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].nbc, vecs[v].par,
                   vecs[v].st2, vecs[v].div, vecs[v].exp_len);

      for (int r = 0; r < 8; r++)
         run_frame($sformatf("rand%0d", r), 8'($urandom), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), -1);

      // Fill while disabled, overflow on the 17th push, then a gapless drain.
      enable = 1'b0;
      data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0; divisor = 16'd2;
      for (int i = 0; i < 17; i++) begin
         wr_data  = 8'(i + 1);
         wr_valid = 1'b1;
         @(negedge clk);
         check($sformatf("ovf pulse push%0d", i), overflow, (i == 16) ? 1 : 0);
         if (i == 15) begin
            check("fill count", fifo_count, 16);
            check("fill full", fifo_full, 1);
         end
      end
      wr_valid = 1'b0;
      @(negedge clk);
      check("ovf single cycle", overflow, 0);
      check("count after drop", fifo_count, 16);
      for (int i = 0; i < 16; i++) add_frame(8'(i + 1), 2'b11, 2'b00, 1'b0, 2);
      enable = 1'b1;
      @(negedge clk);
      compare_stream("b2b16", -1, -1);
      check("b2b empty", fifo_empty, 1);
      check("b2b count", fifo_count, 0);

      // Flush while full with a simultaneous push: everything discarded, no overflow.
      enable = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(i));
      check("pre-flush full", fifo_full, 1);
      flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
      @(negedge clk);
      flush = 1'b0; wr_valid = 1'b0;
      check("flush count", fifo_count, 0);
      check("flush empty", fifo_empty, 1);
      check("flush full", fifo_full, 0);
      check("flush no ovf", overflow, 0);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("flush no frame", busy, 0);

      // count=15 while busy; push 0xA5 on the pop edge at frame end.
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(8'h10 + i);
         wr_valid = 1'b1;
         @(negedge clk);
         check($sformatf("a5 fill ovf%0d", i), overflow, 0);
      end
      wr_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("a5 count before", fifo_count, 15);
      check("a5 stop bit", tx, 1);
      push(8'hA5);
      check("a5 count kept", fifo_count, 15);
      check("a5 no ovf", overflow, 0);
      check("a5 next start", tx, 0);
      begin
         int k = 0;
         while (!(fifo_empty === 1'b1 && busy === 1'b0) && k < 1000) begin
            @(negedge clk);
            k++;
         end
         check("a5 drain done", (k < 1000) ? 1 : 0, 1);
      end

      // Config change mid-frame applies only to the following frame.
      data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0; divisor = 16'd4;
      pend_div = 16'd8; pend_par = 2'b10;
      add_frame(8'h3A, 2'b11, 2'b00, 1'b0, 4);
      add_frame(8'h3A, 2'b11, 2'b10, 1'b0, 8);
      push(8'h3A);
      push(8'h3A);
      compare_stream("midcfg", 10, -1);
      parity = 2'b00; divisor = 16'd4;

      // Reset during data bit 3.
      push(8'h00);
      push(8'h11);
      push(8'h22);
      repeat (16) @(negedge clk);
      check("pre-reset tx", tx, 0);
      check("pre-reset count", fifo_count, 2);
      #1 rst_n = 1'b0;
      #1;
      check("async reset tx", tx, 1);
      check("async reset count", fifo_count, 0);
      check("async reset busy", busy, 0);
      check("async reset empty", fifo_empty, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("post_reset", 8'h00, 2'b11, 2'b00, 1'b0, 4, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
